bus_sram_responder: RTL and testbench

- Bus target (responder) for the same single-initiator burst bus that the DMA drives as initiator.
- Decodes an address window and services single and burst reads/writes into a local word SRAM with byte enables.
- Signals errors for out-of-window accesses.
- Gives the JTAG/DMA path a known memory-mapped target for bring-up and loop-back testing.

---
 rtl/bus_sram_responder_pkg.sv | 16 +
 rtl/bus_sram_responder_if.sv | 30 +++
 rtl/bus_sram_bytewise.sv | 32 +++
 rtl/bus_sram_responder.sv | 190 +++++++++++++++++++
 tb/tb_bus_sram_responder.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/bus_sram_responder_pkg.sv
// Shared definitions for the SRAM bus responder: bus field widths, beat counter width, FSM states.
package bus_defs;
    localparam int DATA_W     = 32;
    localparam int BE_W       = 4;
    localparam int BURST_W    = 8;
    localparam int BEAT_CNT_W = 9;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WRITE,
        ST_READ_FETCH,
        ST_READ,
        ST_READ_END,
        ST_ERR_WRITE
    } state_t;
endpackage

// File: rtl/bus_sram_responder_if.sv
// Single-initiator burst bus; IN/OUT suffixes are named from the responder's side.
interface bus_sram_responder_if;
    import bus_defs::*;

    logic [DATA_W-1:0]  address_dataIN;
    logic [BE_W-1:0]    byte_enableIN;
    logic [BURST_W-1:0] burst_sizeIN;
    logic               read_n_writeIN;
    logic               begin_transactionIN;
    logic               end_transactionIN;
    logic               data_validIN;
    logic               busyIN;
    logic [DATA_W-1:0]  address_dataOUT;
    logic               data_validOUT;
    logic               end_transactionOUT;
    logic               busyOUT;
    logic               errorOUT;

    modport slave (
        input  address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
        input  begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        output address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
    );

    modport master (
        output address_dataIN, byte_enableIN, burst_sizeIN, read_n_writeIN,
        output begin_transactionIN, end_transactionIN, data_validIN, busyIN,
        input  address_dataOUT, data_validOUT, end_transactionOUT, busyOUT, errorOUT
    );
endinterface

// File: rtl/bus_sram_bytewise.sv
// Single-port word SRAM with per-byte write enables and a registered (1-cycle) read port.
module bus_sram_bytewise
    import bus_defs::*;
#(
    parameter int ADDR_BITS = 9
) (
    input  logic                 clock,
    input  logic [BE_W-1:0]      i_we,
    input  logic                 i_re,
    input  logic [ADDR_BITS-1:0] i_addr,
    input  logic [DATA_W-1:0]    i_wdata,
    output logic [DATA_W-1:0]    o_rdata
);

    logic [DATA_W-1:0] r_mem [0:(1<<ADDR_BITS)-1];
    logic [DATA_W-1:0] r_q;

    // No reset on the array or read register so the tools can map this onto block RAM.
    always_ff @(posedge clock) begin
        for (int b = 0; b < BE_W; b++) begin
            if (i_we[b]) begin
                r_mem[i_addr][b*8 +: 8] <= i_wdata[b*8 +: 8];
            end
        end
        if (i_re) begin
            r_q <= r_mem[i_addr];
        end
    end

    assign o_rdata = r_q;

endmodule

// File: rtl/bus_sram_responder.sv
// Bus target serving single/burst reads and writes into a local SRAM window; misses get an error pulse.
//   state       | meaning
//   IDLE        | waiting for begin; miss-read error/end pulse issued from here
//   WRITE       | accepting write beats until end_transactionIN
//   READ_FETCH  | first word leaving the SRAM, next word being prefetched
//   READ        | presenting beats; SRAM read register holds the following word
//   READ_END    | end_transactionOUT pulse after the last beat
//   ERR_WRITE   | swallowing data of a missed write until end_transactionIN
module bus_sram_responder
    import bus_defs::*;
#(
    parameter logic [31:0] BASE_ADDRESS = 32'h5000_0000,
    parameter int          ADDR_BITS    = 9
) (
    input  logic                clock,
    input  logic                n_reset,
    bus_sram_responder_if.slave bus
);

    state_t                  r_state, w_state_nxt;
    logic [ADDR_BITS-1:0]    r_idx, w_idx_nxt;
    logic [BEAT_CNT_W-1:0]   r_cnt, w_cnt_nxt;
    logic [BE_W-1:0]         r_be, w_be_nxt;
    logic [DATA_W-1:0]       r_data, w_data_nxt;
    logic                    r_dv, w_dv_nxt;
    logic                    r_end, w_end_nxt;
    logic                    r_err, w_err_nxt;

    logic                    w_hit;
    logic [ADDR_BITS-1:0]    w_in_idx;
    logic [BEAT_CNT_W-1:0]   w_beats;
    logic                    w_consume;
    logic [BE_W-1:0]         w_ram_we;
    logic                    w_ram_re;
    logic [ADDR_BITS-1:0]    w_ram_addr;
    logic [DATA_W-1:0]       w_ram_q;
    logic                    w_unused_addr;

    assign w_hit         = bus.address_dataIN[31:ADDR_BITS+2] == BASE_ADDRESS[31:ADDR_BITS+2];
    assign w_in_idx      = bus.address_dataIN[ADDR_BITS+1:2];
    assign w_beats       = BEAT_CNT_W'(bus.burst_sizeIN) + BEAT_CNT_W'(1);
    assign w_consume     = r_dv & ~bus.busyIN;
    assign w_unused_addr = &{1'b0, bus.address_dataIN[1:0]};

    bus_sram_bytewise #(
        .ADDR_BITS (ADDR_BITS)
    ) u_sram (
        .clock   (clock),
        .i_we    (w_ram_we),
        .i_re    (w_ram_re),
        .i_addr  (w_ram_addr),
        .i_wdata (bus.address_dataIN),
        .o_rdata (w_ram_q)
    );

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or negedge n_reset) begin
        if (!n_reset) begin
            r_idx  <= '0;
            r_cnt  <= '0;
            r_be   <= '0;
            r_data <= '0;
            r_dv   <= 1'b0;
            r_end  <= 1'b0;
            r_err  <= 1'b0;
        end else begin
            r_idx  <= w_idx_nxt;
            r_cnt  <= w_cnt_nxt;
            r_be   <= w_be_nxt;
            r_data <= w_data_nxt;
            r_dv   <= w_dv_nxt;
            r_end  <= w_end_nxt;
            r_err  <= w_err_nxt;
        end
    end

    // In the read states r_idx points one word past what the SRAM read register already holds.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_be_nxt    = r_be;
        w_data_nxt  = r_data;
        w_dv_nxt    = r_dv;
        w_end_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
        w_ram_we    = '0;
        w_ram_re    = 1'b0;
        w_ram_addr  = r_idx;

        case (r_state)
            ST_IDLE: begin
                w_dv_nxt   = 1'b0;
                w_ram_addr = w_in_idx;
                if (bus.begin_transactionIN) begin
                    if (w_hit) begin
                        w_cnt_nxt = w_beats;
                        w_be_nxt  = bus.byte_enableIN;
                        if (bus.read_n_writeIN) begin
                            w_ram_re    = 1'b1;
                            w_idx_nxt   = w_in_idx + ADDR_BITS'(1);
                            w_state_nxt = ST_READ_FETCH;
                        end else begin
                            w_idx_nxt   = w_in_idx;
                            w_state_nxt = ST_WRITE;
                        end
                    end else begin
                        w_err_nxt = 1'b1;
                        if (bus.read_n_writeIN) begin
                            w_end_nxt = 1'b1;
                        end else begin
                            w_state_nxt = ST_ERR_WRITE;
                        end
                    end
                end
            end

            ST_WRITE: begin
                if (bus.data_validIN && (r_cnt != '0)) begin
                    w_ram_we  = r_be;
                    w_idx_nxt = r_idx + ADDR_BITS'(1);
                    w_cnt_nxt = r_cnt - BEAT_CNT_W'(1);
                end
                if (bus.end_transactionIN) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_ERR_WRITE: begin
                if (bus.end_transactionIN) begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_READ_FETCH: begin
                if (bus.end_transactionIN) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_data_nxt  = w_ram_q;
                    w_dv_nxt    = 1'b1;
                    w_ram_re    = 1'b1;
                    w_idx_nxt   = r_idx + ADDR_BITS'(1);
                    w_state_nxt = ST_READ;
                end
            end

            ST_READ: begin
                if (bus.end_transactionIN) begin
                    w_dv_nxt    = 1'b0;
                    w_state_nxt = ST_IDLE;
                end else if (w_consume) begin
                    if (r_cnt == BEAT_CNT_W'(1)) begin
                        w_dv_nxt    = 1'b0;
                        w_end_nxt   = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = ST_READ_END;
                    end else begin
                        w_data_nxt = w_ram_q;
                        w_ram_re   = 1'b1;
                        w_idx_nxt  = r_idx + ADDR_BITS'(1);
                        w_cnt_nxt  = r_cnt - BEAT_CNT_W'(1);
                    end
                end
            end

            ST_READ_END: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_dv_nxt    = 1'b0;
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    assign bus.address_dataOUT    = r_data;
    assign bus.data_validOUT      = r_dv;
    assign bus.end_transactionOUT = r_end;
    assign bus.errorOUT           = r_err;
    assign bus.busyOUT            = 1'b0;

endmodule

// File: tb/tb_bus_sram_responder.sv
// Randomised bench for bus_sram_responder: a word-array model of the window predicts every output cycle.
module tb_bus_sram_responder;

    localparam logic [31:0] BASE  = 32'h5000_0000;
    localparam int          AB    = 9;
    localparam int          WORDS = 1 << AB;

    logic clock   = 1'b0;
    logic n_reset = 1'b0;

    bus_sram_responder_if bus ();

    bus_sram_responder #(
        .BASE_ADDRESS (BASE),
        .ADDR_BITS    (AB)
    ) dut (
        .clock   (clock),
        .n_reset (n_reset),
        .bus     (bus)
    );

    always #5 clock = ~clock;

    logic [31:0] model [WORDS];
    logic [31:0] wdata_q [$];
    logic [31:0] rx_q [$];
    int          n_checks = 0;
    int          n_fail   = 0;
    logic        chk_en   = 1'b0;
    logic        exp_dv, exp_end, exp_err;
    logic [31:0] exp_data;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic bit is_hit(input logic [31:0] a);
        return (a >> (AB + 2)) == (BASE >> (AB + 2));
    endfunction

    function automatic int word_idx(input logic [31:0] a);
        return int'((a >> 2) & 32'(WORDS - 1));
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw, input logic [3:0] be);
        logic [31:0] mask;
        mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
        return (old & ~mask) | (nw & mask);
    endfunction

    task automatic set_exp(input logic dv, input logic [31:0] d, input logic e, input logic er);
        exp_dv   = dv;
        exp_data = d;
        exp_end  = e;
        exp_err  = er;
    endtask

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    // Single compare point: every cycle, away from the rising edge.
    always @(negedge clock) begin
        if (chk_en) begin
            check("data_validOUT", 32'(bus.data_validOUT), 32'(exp_dv));
            check("end_transactionOUT", 32'(bus.end_transactionOUT), 32'(exp_end));
            check("errorOUT", 32'(bus.errorOUT), 32'(exp_err));
            check("busyOUT", 32'(bus.busyOUT), 32'd0);
            if (exp_dv) check("read_data", bus.address_dataOUT, exp_data);
            if (bus.data_validOUT && !bus.busyIN) rx_q.push_back(bus.address_dataOUT);
        end
    end

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.begin_transactionIN = 1'b0;
            bus.end_transactionIN   = 1'($urandom);
            bus.data_validIN        = 1'($urandom);
            bus.busyIN              = 1'($urandom);
            bus.address_dataIN      = $urandom;
            set_exp(1'b0, 32'h0, 1'b0, 1'b0);
            next_cycle;
        end
        bus.end_transactionIN = 1'b0;
        bus.data_validIN      = 1'b0;
        bus.busyIN            = 1'b0;
    endtask

    task automatic do_write(input logic [31:0] addr, input logic [3:0] be, input int burst,
                            input int nsend, input bit end_last, input bit gaps);
        bit          hit;
        bit          first;
        int          idx;
        int          sent;
        int          written;
        logic [31:0] d;
        hit = is_hit(addr);
        idx = word_idx(addr);
        sent = 0;
        written = 0;
        bus.begin_transactionIN = 1'b1;
        bus.address_dataIN      = addr;
        bus.byte_enableIN       = be;
        bus.burst_sizeIN        = 8'(burst);
        bus.read_n_writeIN      = 1'b0;
        bus.data_validIN        = 1'b0;
        bus.end_transactionIN   = 1'b0;
        bus.busyIN              = 1'b0;
        set_exp(1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle;
        first = 1'b1;
        bus.byte_enableIN = 4'($urandom);
        bus.burst_sizeIN  = 8'($urandom);
        while (sent < nsend) begin
            set_exp(1'b0, 32'h0, 1'b0, first && !hit);
            first = 1'b0;
            bus.begin_transactionIN = ($urandom_range(7) == 0);
            bus.end_transactionIN   = 1'b0;
            if (gaps && $urandom_range(3) == 0) begin
                bus.data_validIN   = 1'b0;
                bus.address_dataIN = $urandom;
            end else begin
                if (wdata_q.size() > 0) d = wdata_q.pop_front();
                else d = $urandom;
                bus.data_validIN   = 1'b1;
                bus.address_dataIN = d;
                sent++;
                if (hit && written < burst + 1) begin
                    model[(idx + written) % WORDS] = merge(model[(idx + written) % WORDS], d, be);
                    written++;
                end
                if (end_last && sent == nsend) bus.end_transactionIN = 1'b1;
            end
            next_cycle;
        end
        if (!(end_last && nsend > 0)) begin
            set_exp(1'b0, 32'h0, 1'b0, first && !hit);
            bus.begin_transactionIN = 1'b0;
            bus.data_validIN        = 1'b0;
            bus.end_transactionIN   = 1'b1;
            next_cycle;
        end
        bus.begin_transactionIN = 1'b0;
        bus.end_transactionIN   = 1'b0;
        bus.data_validIN        = 1'b0;
    endtask

    // abort_at: -1 none, -2 during the fetch cycle, k>=0 while beat k is presented.
    task automatic do_read(input logic [31:0] addr, input int burst, input int busy_pct,
                           input int abort_at, input int stall_beat, input int stall_len);
        bit hit;
        bit bsy;
        int idx;
        int b;
        int stalled;
        int cyc;
        hit = is_hit(addr);
        idx = word_idx(addr);
        rx_q.delete();
        bus.begin_transactionIN = 1'b1;
        bus.address_dataIN      = addr;
        bus.burst_sizeIN        = 8'(burst);
        bus.read_n_writeIN      = 1'b1;
        bus.byte_enableIN       = 4'($urandom);
        bus.data_validIN        = 1'b0;
        bus.end_transactionIN   = 1'b0;
        bus.busyIN              = 1'b0;
        set_exp(1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle;
        bus.begin_transactionIN = hit ? ($urandom_range(3) == 0) : 1'b0;
        bus.address_dataIN      = $urandom;
        bus.burst_sizeIN        = 8'($urandom);
        bus.read_n_writeIN      = 1'($urandom);
        bus.busyIN              = 1'($urandom);
        bus.end_transactionIN   = hit && (abort_at == -2);
        set_exp(1'b0, 32'h0, !hit, !hit);
        next_cycle;
        bus.end_transactionIN = 1'b0;
        if (!hit || abort_at == -2) begin
            bus.begin_transactionIN = 1'b0;
            bus.busyIN              = 1'b0;
            return;
        end
        b = 0;
        stalled = 0;
        cyc = 0;
        while (b <= burst) begin
            set_exp(1'b1, model[(idx + b) % WORDS], 1'b0, 1'b0);
            if (b == stall_beat && stalled < stall_len) begin
                bsy = 1'b1;
                stalled++;
            end else begin
                bsy = ($urandom_range(99) < busy_pct) && (cyc < 1000);
            end
            cyc++;
            bus.busyIN              = bsy;
            bus.begin_transactionIN = ($urandom_range(3) == 0);
            if (b == abort_at) begin
                bus.end_transactionIN = 1'b1;
                next_cycle;
                bus.end_transactionIN   = 1'b0;
                bus.begin_transactionIN = 1'b0;
                bus.busyIN              = 1'b0;
                return;
            end
            next_cycle;
            if (!bsy) b++;
        end
        set_exp(1'b0, 32'h0, 1'b1, 1'b0);
        bus.busyIN              = 1'($urandom);
        bus.begin_transactionIN = 1'($urandom);
        next_cycle;
        bus.begin_transactionIN = 1'b0;
        bus.busyIN              = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached, got %0d checks, required completion", n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] d1, d2, d3;
        bus.address_dataIN      = '0;
        bus.byte_enableIN       = '0;
        bus.burst_sizeIN        = '0;
        bus.read_n_writeIN      = 1'b0;
        bus.begin_transactionIN = 1'b0;
        bus.end_transactionIN   = 1'b0;
        bus.data_validIN        = 1'b0;
        bus.busyIN              = 1'b0;
        set_exp(1'b0, 32'h0, 1'b0, 1'b0);

        #2;
        check("reset_data_valid", 32'(bus.data_validOUT), 32'd0);
        check("reset_end", 32'(bus.end_transactionOUT), 32'd0);
        check("reset_error", 32'(bus.errorOUT), 32'd0);
        check("reset_data", bus.address_dataOUT, 32'd0);
        repeat (2) @(posedge clock);
        #1;
        n_reset = 1'b1;
        chk_en  = 1'b1;
        idle(2);

        // Whole window filled with maximum-length (256-beat) bursts.
        do_write(BASE, 4'hF, 255, 256, 1'b1, 1'b0);
        do_write(BASE + 32'd1024, 4'hF, 255, 256, 1'b0, 1'b0);
        idle(1);

        wdata_q.push_back(32'hDEADBEEF);
        do_write(32'h5000_0010, 4'hF, 0, 1, 1'b1, 1'b0);
        do_read(32'h5000_0010, 0, 0, -1, -1, 0);
        check("single_rd_count", 32'(rx_q.size()), 32'd1);
        check("single_rd_data", rx_q[0], 32'hDEADBEEF);

        wdata_q.push_back(32'hFFFFFFFF);
        do_write(32'h5000_0020, 4'hF, 0, 1, 1'b1, 1'b0);
        wdata_q.push_back(32'h00000000);
        do_write(32'h5000_0020, 4'b0101, 0, 1, 1'b0, 1'b0);
        check("model_merge", model[8], 32'hFF00FF00);
        do_read(32'h5000_0020, 0, 0, -1, -1, 0);
        check("be_merge_rd", rx_q[0], 32'hFF00FF00);

        for (int i = 1; i <= 4; i++) wdata_q.push_back(32'(i));
        do_write(BASE, 4'hF, 3, 4, 1'b1, 1'b0);
        do_read(BASE, 3, 0, -1, 1, 2);
        check("stall_count", 32'(rx_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("stall_order", rx_q[i], 32'(i + 1));

        wdata_q.push_back(32'hA);
        wdata_q.push_back(32'hB);
        do_write(32'h5000_07FC, 4'hF, 1, 2, 1'b1, 1'b0);
        do_read(32'h5000_07FC, 1, 0, -1, -1, 0);
        check("wrap_w511", rx_q[0], 32'hA);
        check("wrap_w0", rx_q[1], 32'hB);

        do_read(32'h6000_0000, 0, 0, -1, -1, 0);
        check("miss_rd_no_data", 32'(rx_q.size()), 32'd0);
        do_write(32'h6000_0000, 4'hF, 0, 2, 1'b1, 1'b0);
        do_read(BASE, 0, 0, -1, -1, 0);
        check("miss_wr_unchanged", rx_q[0], 32'h0000000B);

        do_read(BASE, 7, 0, 1, -1, 0);
        do_read(32'h5000_0010, 0, 0, -1, -1, 0);
        check("after_abort_rd", rx_q[0], 32'hDEADBEEF);

        // Reset while read data is being presented.
        bus.begin_transactionIN = 1'b1;
        bus.address_dataIN      = BASE + 32'd8;
        bus.burst_sizeIN        = 8'd7;
        bus.read_n_writeIN      = 1'b1;
        set_exp(1'b0, 32'h0, 1'b0, 1'b0);
        next_cycle;
        bus.begin_transactionIN = 1'b0;
        next_cycle;
        set_exp(1'b1, model[2], 1'b0, 1'b0);
        bus.busyIN = 1'b1;
        @(negedge clock);
        #1;
        chk_en  = 1'b0;
        n_reset = 1'b0;
        #1;
        check("rst_rd_data_valid", 32'(bus.data_validOUT), 32'd0);
        check("rst_rd_data", bus.address_dataOUT, 32'd0);
        @(posedge clock);
        #1;
        n_reset    = 1'b1;
        bus.busyIN = 1'b0;
        set_exp(1'b0, 32'h0, 1'b0, 1'b0);
        chk_en = 1'b1;
        idle(1);

        // Reset in the middle of a 4-beat write: two beats land, the rest never do.
        d1 = $urandom;
        d2 = $urandom;
        d3 = $urandom;
        bus.begin_transactionIN = 1'b1;
        bus.address_dataIN      = BASE + 32'd400;
        bus.byte_enableIN       = 4'hF;
        bus.burst_sizeIN        = 8'd3;
        bus.read_n_writeIN      = 1'b0;
        next_cycle;
        bus.begin_transactionIN = 1'b0;
        bus.data_validIN        = 1'b1;
        bus.address_dataIN      = d1;
        next_cycle;
        model[100] = d1;
        bus.address_dataIN = d2;
        next_cycle;
        model[101] = d2;
        bus.address_dataIN = d3;
        @(negedge clock);
        #1;
        chk_en  = 1'b0;
        n_reset = 1'b0;
        #1;
        check("rst_wr_error", 32'(bus.errorOUT), 32'd0);
        check("rst_wr_end", 32'(bus.end_transactionOUT), 32'd0);
        @(posedge clock);
        #1;
        bus.data_validIN = 1'b0;
        n_reset = 1'b1;
        chk_en  = 1'b1;
        do_read(BASE + 32'd400, 3, 20, -1, -1, 0);
        check("rst_wr_beat0", rx_q[0], d1);
        check("rst_wr_beat1", rx_q[1], d2);

        for (int it = 0; it < 200; it++) begin
            logic [31:0] a;
            int          burst;
            int          ab;
            burst = int'($urandom_range(15));
            if ($urandom_range(7) == 0) a = $urandom;
            else a = BASE | (32'($urandom_range(WORDS - 1)) << 2) | 32'($urandom_range(3));
            if ($urandom_range(9) < 4) begin
                do_write(a, 4'($urandom), burst, int'($urandom_range(burst + 3)),
                         1'($urandom), 1'($urandom));
            end else begin
                if ($urandom_range(5) == 0) ab = int'($urandom_range(burst + 2)) - 2;
                else ab = -1;
                do_read(a, burst, int'($urandom_range(50)), ab, -1, 0);
            end
            idle(int'($urandom_range(2)));
        end

        idle(2);
        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
